// File: rtl/xge_sync_arb.sv
// Round-robin arbiter that loads one requester word at a time into a slow
// clock-crossing channel, holding it valid for HOLD cycles then idling GAP cycles.
module xge_sync_arb #(
   parameter int             N         = 4,
   parameter int             W         = 32,
   parameter int             HOLD      = 10,
   parameter int             GAP       = 2,
   parameter logic [W-1:0]   CH_PRESET = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       data,
   output logic [N-1:0]         gnt,
   output logic [W-1:0]         ch_data,
   output logic [$clog2(N)-1:0] ch_id,
   output logic                 ch_valid,
   output logic                 busy
);
   localparam int IW    = $clog2(N);
   localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
   localparam int CW    = ($clog2(MAXHG) < 1) ? 1 : $clog2(MAXHG);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [W-1:0]   ch_data_q, ch_data_d;
   logic [IW-1:0]  ch_id_q, ch_id_d;
   logic           ch_valid_q, ch_valid_d;
   logic           busy_q, busy_d;

   // Candidate gi is the requester gi places after ptr, wrapping modulo N.
   logic [IW-1:0]  cand_idx [N];
   logic [N-1:0]   cand_req;

   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, ptr_q} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
   end

   logic           pick_any;
   logic [IW-1:0]  pick_idx;

   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            pick_any = 1'b1;
            pick_idx = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      gnt_d      = '0;
      ch_data_d  = ch_data_q;
      ch_id_d    = ch_id_q;
      ch_valid_d = ch_valid_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (en && pick_any) begin
               state_d    = ST_HOLD;
               gnt_d      = N'(1) << pick_idx;
               ch_data_d  = data[pick_idx*W +: W];
               ch_id_d    = pick_idx;
               ch_valid_d = 1'b1;
               busy_d     = 1'b1;
               ptr_d      = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
               cnt_d      = CW'(HOLD - 1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               ch_valid_d = 1'b0;
               cnt_d      = CW'(GAP - 1);
               state_d    = ST_GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ch_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         ch_data_q  <= CH_PRESET;
         ch_id_q    <= '0;
         ch_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         ch_data_q  <= ch_data_d;
         ch_id_q    <= ch_id_d;
         ch_valid_q <= ch_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt      = gnt_q;
   assign ch_data  = ch_data_q;
   assign ch_id    = ch_id_q;
   assign ch_valid = ch_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_xge_sync_arb.sv
// Scoreboard bench for xge_sync_arb: default build plus an N=3, HOLD=1, GAP=1 build.
module tb_xge_sync_arb;
   localparam int N = 4, W = 32, HOLD = 10, GAP = 2;
   localparam logic [31:0] PRESET  = 32'h0BAD_F00D;
   localparam logic [7:0]  PRESET2 = 8'h5A;
   localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001,
                           D2 = 32'hA5A5_0001, D3 = 32'h4444_0003;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, en;
   logic [N-1:0]     req;
   logic [N*W-1:0]   data;
   logic [N-1:0]     gnt;
   logic [W-1:0]     ch_data;
   logic [1:0]       ch_id;
   logic             ch_valid, busy;

   logic             rst2_n, en2;
   logic [2:0]       req2;
   logic [23:0]      data2;
   logic [2:0]       gnt2;
   logic [7:0]       ch_data2;
   logic [1:0]       ch_id2;
   logic             ch_valid2, busy2;

   xge_sync_arb #(.N(N), .W(W), .HOLD(HOLD), .GAP(GAP), .CH_PRESET(PRESET)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data(data),
      .gnt(gnt), .ch_data(ch_data), .ch_id(ch_id), .ch_valid(ch_valid), .busy(busy));

   xge_sync_arb #(.N(3), .W(8), .HOLD(1), .GAP(1), .CH_PRESET(PRESET2)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .en(en2), .req(req2), .data(data2),
      .gnt(gnt2), .ch_data(ch_data2), .ch_id(ch_id2), .ch_valid(ch_valid2), .busy(busy2));

   typedef struct {int id; logic [31:0] d; int gap;} exp_t;
   exp_t q[$];
   exp_t q2[$];

   int tests = 0, fails = 0;
   int cyc = 0, last_gnt = -1000, vcnt = 0, gnt_seen = 0;
   int last2 = -1000, vcnt2 = 0;
   logic busy_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor for the default build: pops one expectation per gnt pulse.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         vcnt      = 0;
         busy_prev = 1'b0;
      end else begin
         if (gnt !== '0) begin
            gnt_seen++;
            if (q.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'd0);
            else begin
               e = q.pop_front();
               chk("gnt", 64'(gnt), 64'(1) << e.id);
               chk("ch_id", 64'(ch_id), 64'(e.id));
               chk("ch_data", 64'(ch_data), 64'(e.d));
               chk("ch_valid_on_gnt", 64'(ch_valid), 64'd1);
               if (e.gap != 0) chk("gnt_spacing", 64'(cyc - last_gnt), 64'(e.gap));
            end
            last_gnt = cyc;
         end
         if (ch_valid) vcnt++;
         else if (vcnt != 0) begin
            chk("valid_len", 64'(vcnt), 64'(HOLD));
            vcnt = 0;
         end
         if (busy_prev && !busy) chk("busy_len", 64'(cyc - last_gnt), 64'(HOLD + GAP));
         busy_prev = busy;
      end
   end

   // Monitor for the N=3 corner build.
   always @(negedge clk) begin
      exp_t e;
      if (!rst2_n) vcnt2 = 0;
      else begin
         if (gnt2 !== '0) begin
            if (q2.size() == 0) chk("unexpected_gnt2", 64'(gnt2), 64'd0);
            else begin
               e = q2.pop_front();
               chk("gnt2", 64'(gnt2), 64'(1) << e.id);
               chk("ch_id2", 64'(ch_id2), 64'(e.id));
               chk("ch_data2", 64'(ch_data2), 64'(e.d[7:0]));
               chk("ptr2_range", 64'(u_dut2.ptr_q < 2'd3), 64'd1);
               if (e.gap != 0) chk("gnt2_spacing", 64'(cyc - last2), 64'(e.gap));
            end
            last2 = cyc;
         end
         if (ch_valid2) vcnt2++;
         else if (vcnt2 != 0) begin
            chk("valid2_len", 64'(vcnt2), 64'd1);
            vcnt2 = 0;
         end
      end
   end

   task automatic push(input int id, input logic [31:0] d, input int gap);
      exp_t e;
      e.id = id; e.d = d; e.gap = gap;
      q.push_back(e);
   endtask

   task automatic push2(input int id, input logic [31:0] d, input int gap);
      exp_t e;
      e.id = id; e.d = d; e.gap = gap;
      q2.push_back(e);
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (gnt === '0 && n < 40);
      if (gnt === '0) begin
         tests++; fails++;
         $display("FAIL gnt_timeout: no gnt within %0d cycles", n);
      end
   endtask

   task automatic wait_gnt2(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (gnt2 === '0 && n < 20);
      if (gnt2 === '0) begin
         tests++; fails++;
         $display("FAIL gnt2_timeout: no gnt within %0d cycles", n);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy !== 1'b0) begin
         tests++; fails++;
         $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, s;
      rst_n = 1'b1; en = 1'b0; req = '0;
      data = {D3, D2, D1, D0};
      rst2_n = 1'b1; en2 = 1'b0; req2 = '0;
      data2 = {8'hC2, 8'hB1, 8'hA0};
      #1 rst_n = 1'b0; rst2_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_ch_valid", 64'(ch_valid), 64'd0);
      chk("rst_ch_data", 64'(ch_data), 64'(PRESET));
      chk("rst_ch_id", 64'(ch_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst2_ch_data", 64'(ch_data2), 64'(PRESET2));

      // Single request from requester 2
      rst_n = 1'b1; en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push(2, D2, 0);
      req = 4'b0100;
      wait_gnt(n);
      chk("single_latency", 64'(n), 64'd1);
      req = '0;
      wait_idle();

      // Round robin with all requests held through reset
      rst_n = 1'b0; req = 4'b1111;
      push(0, D0, 0); push(1, D1, 13); push(2, D2, 13); push(3, D3, 13); push(0, D0, 13);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_gnt(n);
      chk("rr_first_latency", 64'(n), 64'd1);
      for (int i = 0; i < 4; i++) begin
         wait_gnt(n);
         chk("rr_gap", 64'(n), 64'd13);
      end
      req = '0;
      wait_idle();

      // Pointer skip and wrap
      push(3, D3, 0);
      req = 4'b1000;
      wait_gnt(n);
      push(1, D1, 13);
      req = 4'b0010;
      wait_gnt(n);
      push(0, D0, 13);
      req = 4'b0011;
      wait_gnt(n);
      req = '0;
      wait_idle();

      // Enable drops during HOLD; transfer finishes, nothing new starts
      push(0, D0, 0);
      req = 4'b0001;
      wait_gnt(n);
      repeat (2) @(posedge clk);
      #1 en = 1'b0;
      s = gnt_seen;
      repeat (30) @(posedge clk);
      #1;
      chk("no_gnt_en_low", 64'(gnt_seen - s), 64'd0);
      chk("busy_en_low", 64'(busy), 64'd0);
      push(0, D0, 0);
      en = 1'b1;
      wait_gnt(n);
      chk("en_return_latency", 64'(n), 64'd1);
      req = '0;
      wait_idle();

      // Asynchronous reset in the middle of HOLD
      push(3, D3, 0);
      req = 4'b1000;
      wait_gnt(n);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_ch_valid", 64'(ch_valid), 64'd0);
      chk("abort_ch_data", 64'(ch_data), 64'(PRESET));
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_gnt", 64'(gnt), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push(3, D3, 0);
      wait_gnt(n);
      chk("post_reset_latency", 64'(n), 64'd1);
      req = '0;
      wait_idle();

      // N=3, HOLD=1, GAP=1 corner
      push2(0, 32'hA0, 0); push2(1, 32'hB1, 3); push2(2, 32'hC2, 3); push2(0, 32'hA0, 3);
      req2 = 3'b111; en2 = 1'b1;
      @(posedge clk);
      #1 rst2_n = 1'b1;
      wait_gnt2(n);
      chk("n3_first_latency", 64'(n), 64'd1);
      for (int i = 0; i < 3; i++) begin
         wait_gnt2(n);
         chk("n3_gap", 64'(n), 64'd3);
      end
      req2 = '0;
      repeat (6) @(posedge clk);
      #1;
      chk("q_empty", 64'(q.size()), 64'd0);
      chk("q2_empty", 64'(q2.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
